joltage_ascii_parser: RTL and testbench

Upstream neighbour of the joltage calculation unit. Consumes the puzzle input as a byte stream from the UART receive path, one ASCII character per handshake. Produces the per-battery joltage digit stream that the calculation unit consumes:
- joltage value
- valid
- bank_end, asserted with the last digit of each bank
- end_of_puzzle_tx, asserted on a final strobe

It holds one digit back so that bank_end can be attached to the final digit of a line.

---
 rtl/joltage_ascii_parser.sv | 160 ++++++++++++++++
 tb/tb_joltage_ascii_parser.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/joltage_ascii_parser.sv
// joltage_ascii_parser: turns the ASCII puzzle byte stream into per-battery joltage digit strobes.
// Latency: a byte accepted in cycle N affects the registered outputs in cycle N+1. One digit is held
//   back so that bank_end can be attached to the last digit of a line.
// Backpressure: rx_ready is low only during the single FLUSH cycle that follows an EOT which had a
//   digit pending. No backpressure from downstream is accepted.
// Ports: clk/reset (sync, active-high); rx_data/rx_valid/rx_ready byte handshake;
//   joltage_out/joltage_out_valid/bank_end/end_of_puzzle_tx digit strobe;
//   parse_error (sticky), bank_count (saturating), done.
module joltage_ascii_parser #(
  parameter int BANK_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [3:0]            joltage_out,
  output logic                  joltage_out_valid,
  output logic                  bank_end,
  output logic                  end_of_puzzle_tx,
  output logic                  parse_error,
  output logic [BANK_CNT_W-1:0] bank_count,
  output logic                  done
);

  localparam logic [1:0] ST_PARSE = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [7:0] CH_NL  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_EOT = 8'h04;

  localparam logic [BANK_CNT_W-1:0] CNT_ONE = {{(BANK_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BANK_CNT_W-1:0] CNT_MAX = {BANK_CNT_W{1'b1}};

  logic [1:0]            state_q, state_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [3:0]            pend_val_q, pend_val_d;
  logic [1:0]            digits_q, digits_d;
  logic                  rx_ready_q, rx_ready_d;
  logic [3:0]            jolt_q, jolt_d;
  logic                  vld_q, vld_d;
  logic                  be_q, be_d;
  logic                  eop_q, eop_d;
  logic                  err_q, err_d;
  logic [BANK_CNT_W-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;

  logic accept;
  logic is_digit;

  assign accept   = rx_valid & rx_ready_q;
  assign is_digit = (rx_data >= 8'h31) && (rx_data <= 8'h39);

  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;
    digits_d   = digits_q;
    jolt_d     = 4'd0;
    vld_d      = 1'b0;
    be_d       = 1'b0;
    eop_d      = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_PARSE: begin
        if (accept) begin
          if (is_digit) begin
            // Release the previously held digit; it cannot be the last of its bank.
            if (pend_vld_q) begin
              jolt_d = pend_val_q;
              vld_d  = 1'b1;
            end
            pend_vld_d = 1'b1;
            pend_val_d = rx_data[3:0];
            if (digits_q != 2'd3) digits_d = digits_q + 2'd1;
          end else if (rx_data == CH_NL || rx_data == CH_EOT) begin
            // Both terminate the current bank; a bank of exactly one digit is malformed.
            if (pend_vld_q) begin
              jolt_d     = pend_val_q;
              vld_d      = 1'b1;
              be_d       = 1'b1;
              pend_vld_d = 1'b0;
              if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            end
            if (digits_q == 2'd1) err_d = 1'b1;
            digits_d = 2'd0;
            if (rx_data == CH_EOT) begin
              if (pend_vld_q) begin
                // End strobe must not share a cycle with the final digit.
                state_d = ST_FLUSH;
              end else begin
                vld_d   = 1'b1;
                eop_d   = 1'b1;
                state_d = ST_DONE;
              end
            end
          end else if (rx_data != CH_CR) begin
            err_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        vld_d   = 1'b1;
        eop_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // Everything is swallowed until reset.
      end
      default: state_d = ST_PARSE;
    endcase
  end

  assign rx_ready_d = (state_d != ST_FLUSH);
  assign done_d     = (state_d == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_PARSE;
      pend_vld_q <= 1'b0;
      pend_val_q <= 4'd0;
      digits_q   <= 2'd0;
      rx_ready_q <= 1'b1;
      jolt_q     <= 4'd0;
      vld_q      <= 1'b0;
      be_q       <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_val_q <= pend_val_d;
      digits_q   <= digits_d;
      rx_ready_q <= rx_ready_d;
      jolt_q     <= jolt_d;
      vld_q      <= vld_d;
      be_q       <= be_d;
      eop_q      <= eop_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  assign rx_ready          = rx_ready_q;
  assign joltage_out       = jolt_q;
  assign joltage_out_valid = vld_q;
  assign bank_end          = be_q;
  assign end_of_puzzle_tx  = eop_q;
  assign parse_error       = err_q;
  assign bank_count        = cnt_q;
  assign done              = done_q;

endmodule

// File: tb/tb_joltage_ascii_parser.sv
// Testbench for joltage_ascii_parser: scoreboard of expected strobes built from a line-oriented
// reference model, a free-running monitor comparing every output strobe, directed and random cases.
module tb_joltage_ascii_parser;

  localparam int CW  = 3;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [3:0]    joltage_out;
  logic          joltage_out_valid;
  logic          bank_end;
  logic          end_of_puzzle_tx;
  logic          parse_error;
  logic [CW-1:0] bank_count;
  logic          done;

  joltage_ascii_parser #(.BANK_CNT_W(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .joltage_out      (joltage_out),
    .joltage_out_valid(joltage_out_valid),
    .bank_end         (bank_end),
    .end_of_puzzle_tx (end_of_puzzle_tx),
    .parse_error      (parse_error),
    .bank_count       (bank_count),
    .done             (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] j;
    logic       be;
    logic       eop;
  } exp_t;

  typedef logic [7:0] bytes_t[$];

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (joltage_out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_strobe: got j=%0d be=%0d eop=%0d expected no strobe",
                 joltage_out, bank_end, end_of_puzzle_tx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_joltage", int'(joltage_out), int'(e.j));
        chk("strobe_bank_end", int'(bank_end), int'(e.be));
        chk("strobe_eop", int'(end_of_puzzle_tx), int'(e.eop));
      end
    end else if (end_of_puzzle_tx) begin
      checks++;
      $display("FAIL eop_without_valid: got eop=1 expected 0");
    end
  end

  function automatic bytes_t str2q(input string s);
    bytes_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference model: split the stream into lines, keep only digits, one strobe per digit with the
  // last digit of a non-empty line flagged, end strobe at EOT; nothing after EOT matters.
  task automatic model(input bytes_t s, output int banks, output bit err, output bit eot);
    logic [3:0] cur[$];
    banks = 0; err = 1'b0; eot = 1'b0;
    for (int i = 0; i < s.size(); i++) begin
      logic [7:0] c;
      c = s[i];
      if (c >= 8'h31 && c <= 8'h39) begin
        cur.push_back(4'(c - 8'h30));
      end else if (c == 8'h0A || c == 8'h04) begin
        if (cur.size() == 1) err = 1'b1;
        if (cur.size() > 0) begin
          for (int k = 0; k < cur.size(); k++)
            sb.push_back('{j: cur[k], be: (k == cur.size() - 1), eop: 1'b0});
          banks++;
        end
        cur.delete();
        if (c == 8'h04) begin
          sb.push_back('{j: 4'd0, be: 1'b0, eop: 1'b1});
          eot = 1'b1;
          break;
        end
      end else if (c != 8'h0D) begin
        err = 1'b1;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send(input logic [7:0] b, output int waits);
    rx_valid = 1'b1;
    rx_data  = b;
    waits    = 0;
    while (!rx_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!rx_ready) begin
      checks++;
      $display("FAIL send_timeout: rx_ready still 0 after %0d cycles, required 1", waits);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_rx_ready", int'(rx_ready), 1);
    chk("rst_valid", int'(joltage_out_valid), 0);
    chk("rst_bank_count", int'(bank_count), 0);
    chk("rst_parse_error", int'(parse_error), 0);
    chk("rst_done", int'(done), 0);
    sb.delete();
    reset = 1'b0;
  endtask

  task automatic run_case(input string name, input bytes_t s, input bit rst);
    int banks, w;
    bit err, eot;
    if (rst) do_reset();
    model(s, banks, err, eot);
    for (int i = 0; i < s.size(); i++) begin
      send(s[i], w);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(6);
    chk({name, "_sb_empty"}, sb.size(), 0);
    chk({name, "_bank_count"}, int'(bank_count), (banks > SAT) ? SAT : banks);
    chk({name, "_parse_error"}, int'(parse_error), int'(err));
    chk({name, "_done"}, int'(done), int'(eot));
    chk({name, "_rx_ready"}, int'(rx_ready), 1);
  endtask

  function automatic bytes_t rand_stream();
    bytes_t q;
    int lines;
    lines = $urandom_range(0, 12);
    for (int l = 0; l < lines; l++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 19))
          0:       q.push_back(8'h0D);
          1:       q.push_back(8'h30);
          2:       q.push_back(8'(($urandom_range(0, 1) == 0) ? 8'h61 : 8'hC5));
          default: q.push_back(8'(8'h31 + $urandom_range(0, 8)));
        endcase
      end
      if ($urandom_range(0, 3) != 0 || l != lines - 1) q.push_back(8'h0A);
    end
    q.push_back(8'h04);
    for (int k = 0; k < $urandom_range(0, 3); k++) q.push_back(8'h39);
    return q;
  endfunction

  initial begin
    bytes_t q;
    int w, banks;
    bit err, eot;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    q = str2q("8119\n");     q.push_back(8'h04); run_case("t_8119", q, 1'b1);
    q = str2q("12\r\n34");   q.push_back(8'h04); run_case("t_crlf", q, 1'b1);
    q = str2q("\n\n56\n");   q.push_back(8'h04); run_case("t_blank", q, 1'b1);
    q = str2q("7\n");        q.push_back(8'h04); run_case("t_single", q, 1'b1);
    q = str2q("9a08\n");     q.push_back(8'h04); run_case("t_illegal", q, 1'b1);
    // Bytes after EOT are swallowed in DONE.
    q = str2q("8\n");        q.push_back(8'h04);
    q.push_back(8'h39); q.push_back(8'h39); q.push_back(8'h0A);
    run_case("t_after_done", q, 1'b1);

    // Reset while '4' is held back: it must never appear.
    do_reset();
    send(8'h34, w);
    idle(1);
    do_reset();
    q = str2q("23\n"); run_case("t_mid_reset", q, 1'b0);

    // EOT with pending digit, next byte presented back-to-back: stalls one FLUSH cycle.
    do_reset();
    q = str2q("3"); q.push_back(8'h04);
    model(q, banks, err, eot);
    send(8'h33, w);
    send(8'h04, w);
    send(8'h35, w);
    chk("flush_wait_cycles", w, 1);
    idle(4);
    chk("flush_sb_empty", sb.size(), 0);
    chk("flush_done", int'(done), 1);
    chk("flush_parse_error", int'(parse_error), int'(err));
    chk("flush_bank_count", int'(bank_count), banks);

    for (int r = 0; r < 25; r++) run_case("t_rand", rand_stream(), 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
